// File: rtl/bank_cmd_issuer_pkg.sv
// rtl/bank_cmd_issuer_pkg.sv - shared command/state types and default DRAM timing
//
// Purpose: command and bank-state enumerations plus the default timing values
//          shared between the command issuer and the bank timing model.
// Ports:   none (package).
package bank_cmd_issuer_pkg;

  localparam int T_CL_DEF   = 17;
  localparam int T_RCD_DEF  = 17;
  localparam int T_RP_DEF   = 17;
  localparam int T_RFC_DEF  = 34;
  localparam int BL_DEF     = 8;
  localparam int T_REFI_DEF = 7800;
  localparam int ROW_W_DEF  = 16;
  localparam int COL_W_DEF  = 10;

  typedef enum logic [2:0] {NOP, ACT, RD, WR, PR, REF} cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT_WAIT,
    S_OPEN,
    S_CAS_WAIT,
    S_BURST,
    S_PRE_WAIT,
    S_REF_WAIT
  } state_e;

  // Column command for a request direction.
  function automatic cmd_e cas_cmd(input logic we);
    return we ? WR : RD;
  endfunction

endpackage

// File: rtl/bank_cmd_issuer_if.sv
// rtl/bank_cmd_issuer_if.sv - host request port and DRAM command bus of one bank
//
// Purpose: groups the valid/ready request port and the command/data-enable outputs.
// Ports:   req_valid/req_ready/req_we/req_row/req_col (request side),
//          cmd_act/cmd_rd/cmd_wr/cmd_pr/cmd_ref/cmd_row/cmd_col/data_en (command side).
//          master = host/requester view, slave = command issuer view.
interface bank_cmd_issuer_if #(
  parameter int ROW_W = 16,
  parameter int COL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             cmd_act;
  logic             cmd_rd;
  logic             cmd_wr;
  logic             cmd_pr;
  logic             cmd_ref;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             data_en;

  modport master (
    output req_valid, req_we, req_row, req_col,
    input  req_ready, cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref, cmd_row, cmd_col, data_en
  );

  modport slave (
    input  req_valid, req_we, req_row, req_col,
    output req_ready, cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref, cmd_row, cmd_col, data_en
  );
endinterface

// File: rtl/bank_cmd_issuer_refi_timer.sv
// rtl/bank_cmd_issuer_refi_timer.sv - refresh interval down-counter
//
// Purpose: counts down from T_REFI, saturating at zero; ref_due while at zero.
// Ports:   clk, rst (sync, active-high), reload (load T_REFI, same edge as REF issue),
//          ref_due (out).
module bank_cmd_issuer_refi_timer #(
  parameter int T_REFI = 7800
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic ref_due
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      count <= 16'(T_REFI);
    end else if (count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign ref_due = (count == 16'd0);

endmodule

// File: rtl/bank_cmd_issuer.sv
// rtl/bank_cmd_issuer.sv - open-page ACT/RD/WR/PR/REF issuer for one DRAM bank
//
// Purpose: accepts read/write requests and issues registered single-cycle command
//          pulses honouring tRCD, tCL, tRP, tRFC, burst length and periodic refresh.
// Ports:   clk, rst (sync, active-high), bus (slave modport: request port in,
//          command pulses, cmd_row/cmd_col and data_en out).
module bank_cmd_issuer
  import bank_cmd_issuer_pkg::*;
#(
  parameter int T_CL   = T_CL_DEF,
  parameter int T_RCD  = T_RCD_DEF,
  parameter int T_RP   = T_RP_DEF,
  parameter int T_RFC  = T_RFC_DEF,
  parameter int BL     = BL_DEF,
  parameter int T_REFI = T_REFI_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF
) (
  input logic           clk,
  input logic           rst,
  bank_cmd_issuer_if.slave bus
);

  if (T_CL < 1 || T_CL > 255 || T_RCD < 1 || T_RCD > 255 || T_RP < 1 || T_RP > 255 ||
      T_RFC < 1 || T_RFC > 255 || BL < 1 || BL > 255 || T_REFI < 1 || T_REFI > 65535)
  begin : g_bad_timing
    $error("bank_cmd_issuer: timing parameter out of range");
  end

  state_e           state_q, state_d;
  logic [7:0]       tmr_q, tmr_d;
  logic             pend_q, pend_d;
  logic             pend_we_q, pend_we_d;
  logic [ROW_W-1:0] pend_row_q, pend_row_d;
  logic [COL_W-1:0] pend_col_q, pend_col_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  logic [ROW_W-1:0] cmd_row_q, cmd_row_d;
  logic [COL_W-1:0] cmd_col_q, cmd_col_d;
  logic             act_q, rd_q, wr_q, pr_q, ref_q, data_en_q;
  cmd_e             next_cmd;
  logic             ref_due;
  logic             req_ready;
  logic             accept;

  bank_cmd_issuer_refi_timer #(.T_REFI(T_REFI)) u_refi (
    .clk     (clk),
    .rst     (rst),
    .reload  (next_cmd == REF),
    .ref_due (ref_due)
  );

  // Refresh has priority over a waiting request; rst gates ready in the reset cycle.
  assign req_ready = !rst && (state_q == S_IDLE || state_q == S_OPEN) && !ref_due && !pend_q;
  assign accept    = bus.req_valid && req_ready;

  // Timer loads are "cycles - 1": a state holding N cycles leaves when tmr_q reaches 0,
  // so the command decided in that cycle appears exactly N cycles after the previous one.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    pend_d     = pend_q;
    pend_we_d  = pend_we_q;
    pend_row_d = pend_row_q;
    pend_col_d = pend_col_q;
    open_row_d = open_row_q;
    cmd_row_d  = cmd_row_q;
    cmd_col_d  = cmd_col_q;
    next_cmd   = NOP;

    case (state_q)
      S_IDLE: begin
        if (ref_due) begin
          next_cmd = REF;
          state_d  = S_REF_WAIT;
          tmr_d    = 8'(T_RFC - 1);
        end else if (accept) begin
          next_cmd   = ACT;
          cmd_row_d  = bus.req_row;
          open_row_d = bus.req_row;
          pend_d     = 1'b1;
          pend_we_d  = bus.req_we;
          pend_row_d = bus.req_row;
          pend_col_d = bus.req_col;
          state_d    = S_ACT_WAIT;
          tmr_d      = 8'(T_RCD - 1);
        end
      end
      S_OPEN: begin
        if (ref_due) begin
          // No pend: PRE_WAIT will follow with REF instead of ACT.
          next_cmd = PR;
          state_d  = S_PRE_WAIT;
          tmr_d    = 8'(T_RP - 1);
        end else if (accept) begin
          if (bus.req_row == open_row_q) begin
            next_cmd  = cas_cmd(bus.req_we);
            cmd_col_d = bus.req_col;
            state_d   = S_CAS_WAIT;
            tmr_d     = 8'(T_CL - 1);
          end else begin
            next_cmd   = PR;
            pend_d     = 1'b1;
            pend_we_d  = bus.req_we;
            pend_row_d = bus.req_row;
            pend_col_d = bus.req_col;
            state_d    = S_PRE_WAIT;
            tmr_d      = 8'(T_RP - 1);
          end
        end
      end
      S_ACT_WAIT: begin
        if (tmr_q == 8'd0) begin
          next_cmd  = cas_cmd(pend_we_q);
          cmd_col_d = pend_col_q;
          pend_d    = 1'b0;
          state_d   = S_CAS_WAIT;
          tmr_d     = 8'(T_CL - 1);
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_CAS_WAIT: begin
        if (tmr_q == 8'd0) begin
          state_d = S_BURST;
          tmr_d   = 8'(BL - 1);
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_BURST: begin
        if (tmr_q == 8'd0) begin
          state_d = S_OPEN;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_PRE_WAIT: begin
        if (tmr_q == 8'd0) begin
          if (pend_q) begin
            next_cmd   = ACT;
            cmd_row_d  = pend_row_q;
            open_row_d = pend_row_q;
            state_d    = S_ACT_WAIT;
            tmr_d      = 8'(T_RCD - 1);
          end else begin
            next_cmd = REF;
            state_d  = S_REF_WAIT;
            tmr_d    = 8'(T_RFC - 1);
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_REF_WAIT: begin
        if (tmr_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= 8'd0;
      pend_q     <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_row_q <= '0;
      pend_col_q <= '0;
      open_row_q <= '0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
      act_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      pr_q       <= 1'b0;
      ref_q      <= 1'b0;
      data_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pend_q     <= pend_d;
      pend_we_q  <= pend_we_d;
      pend_row_q <= pend_row_d;
      pend_col_q <= pend_col_d;
      open_row_q <= open_row_d;
      cmd_row_q  <= cmd_row_d;
      cmd_col_q  <= cmd_col_d;
      act_q      <= (next_cmd == ACT);
      rd_q       <= (next_cmd == RD);
      wr_q       <= (next_cmd == WR);
      pr_q       <= (next_cmd == PR);
      ref_q      <= (next_cmd == REF);
      data_en_q  <= (state_d == S_BURST);
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.cmd_act   = act_q;
  assign bus.cmd_rd    = rd_q;
  assign bus.cmd_wr    = wr_q;
  assign bus.cmd_pr    = pr_q;
  assign bus.cmd_ref   = ref_q;
  assign bus.cmd_row   = cmd_row_q;
  assign bus.cmd_col   = cmd_col_q;
  assign bus.data_en   = data_en_q;

endmodule

// File: tb/tb_bank_cmd_issuer.sv
// tb/tb_bank_cmd_issuer.sv - scoreboard bench for bank_cmd_issuer
module tb_bank_cmd_issuer;
  import bank_cmd_issuer_pkg::*;

  localparam int T_CL   = 4;
  localparam int T_RCD  = 3;
  localparam int T_RP   = 2;
  localparam int T_RFC  = 5;
  localparam int BL     = 4;
  localparam int T_REFI = 100;
  localparam int ROW_W  = 16;
  localparam int COL_W  = 10;
  localparam int N_CYC  = 3000;

  typedef struct {
    int   cyc;
    cmd_e kind;
    int   addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;
  bit   prev_rst = 1'b1;

  ev_t  exp_q[$];
  bit   exp_data[int];

  // Reference model state: the bank is free (idle/open) from free_at on, refresh
  // becomes due T_REFI cycles after ref_base.
  int   free_at = 0;
  int   ref_base = 0;
  int   open_row = 0;
  bit   row_open = 1'b0;
  bit   m_due, m_ready;
  int   m_a, m_cas, m_rc, m_n, m_stale;
  cmd_e m_kind;
  ev_t  m_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_cmd_issuer_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  bank_cmd_issuer #(
    .T_CL(T_CL), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .BL(BL),
    .T_REFI(T_REFI), .ROW_W(ROW_W), .COL_W(COL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input cmd_e k, input int a);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // Reference model: predicts acceptance and schedules the expected command trace.
  always @(negedge clk) begin
    m_due   = (cyc >= ref_base + T_REFI);
    m_ready = !rst && (cyc >= free_at) && !m_due;
    if (cyc > 0) check("req_ready", 32'(bus.req_ready), 32'(m_ready));
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > cyc) void'(exp_q.pop_back());
      for (int k = cyc + 1; k <= cyc + 64; k++) if (exp_data.exists(k)) exp_data.delete(k);
      free_at  = cyc + 1;
      ref_base = cyc + 1;
      row_open = 1'b0;
    end else if (cyc >= free_at) begin
      if (m_due) begin
        if (row_open) begin
          push(cyc + 1, PR, 0);
          m_rc = cyc + 1 + T_RP;
        end else begin
          m_rc = cyc + 1;
        end
        push(m_rc, REF, 0);
        ref_base = m_rc;
        free_at  = m_rc + T_RFC;
        row_open = 1'b0;
      end else if (bus.req_valid) begin
        if (row_open && int'(bus.req_row) == open_row) begin
          m_cas = cyc + 1;
        end else begin
          if (row_open) begin
            push(cyc + 1, PR, 0);
            m_a = cyc + 1 + T_RP;
          end else begin
            m_a = cyc + 1;
          end
          push(m_a, ACT, int'(bus.req_row));
          m_cas = m_a + T_RCD;
        end
        push(m_cas, bus.req_we ? WR : RD, int'(bus.req_col));
        for (int b = 0; b < BL; b++) exp_data[m_cas + T_CL + b] = 1'b1;
        free_at  = m_cas + T_CL + BL;
        row_open = 1'b1;
        open_row = int'(bus.req_row);
      end
    end
  end

  // Monitor: compares every presented command pulse and data_en against the scoreboard.
  always @(negedge clk) begin
    if (cyc > 0) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL cmd_missing at cycle %0d: got nothing, expected %s at cycle %0d",
                 cyc, exp_q[0].kind.name(), exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      m_n = int'(bus.cmd_act) + int'(bus.cmd_rd) + int'(bus.cmd_wr) + int'(bus.cmd_pr) + int'(bus.cmd_ref);
      if (m_n > 0) begin
        check("cmd_pulses", 32'(m_n), 32'(1));
        if (bus.cmd_act)     m_kind = ACT;
        else if (bus.cmd_rd) m_kind = RD;
        else if (bus.cmd_wr) m_kind = WR;
        else if (bus.cmd_pr) m_kind = PR;
        else                 m_kind = REF;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected at cycle %0d: got %s, expected none", cyc, m_kind.name());
        end else begin
          m_e = exp_q.pop_front();
          check("cmd_cycle", 32'(cyc), 32'(m_e.cyc));
          check("cmd_kind", 32'(m_kind), 32'(m_e.kind));
          if (m_kind == ACT) check("cmd_row", 32'(bus.cmd_row), 32'(m_e.addr));
          if (m_kind == RD || m_kind == WR) check("cmd_col", 32'(bus.cmd_col), 32'(m_e.addr));
        end
      end
      check("data_en", 32'(bus.data_en), 32'(exp_data.exists(cyc)));
      if (prev_rst) begin
        check("rst_cmd_row", 32'(bus.cmd_row), 32'(0));
        check("rst_cmd_col", 32'(bus.cmd_col), 32'(0));
      end
    end
    prev_rst = rst;
    if (done) begin
      m_stale = 0;
      foreach (exp_q[i]) if (exp_q[i].cyc <= cyc) m_stale++;
      check("stale_events", 32'(m_stale), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin : stim
    bit hs;
    bit did_mid;
    did_mid       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      hs = bus.req_valid && bus.req_ready;
      @(posedge clk);
      #1;
      if (hs) bus.req_valid = 1'b0;
      if (!bus.req_valid && $urandom_range(0, 2) != 0) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_row   = 16'($urandom_range(0, 3));
        bus.req_col   = 10'($urandom_range(0, 1023));
      end
      rst = ($urandom_range(0, 399) == 0);
      if (!did_mid && i >= N_CYC / 2 && exp_data.exists(cyc) && row_open) begin
        // Reset mid-burst, then ask for the row that was open before the reset.
        rst           = 1'b1;
        did_mid       = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_row   = 16'(open_row);
      end
    end
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule
